if_id_stage: RTL and testbench

Instruction-fetch return path and IF/ID pipeline register for the 5-stage RV32I core. It sits directly downstream of the PC register and the synchronous instruction SRAM. It aligns each one-cycle-late SRAM word with the PC that fetched it, absorbs decode stalls in a 2-entry skid FIFO, and back-pressures the PC register through `pc_hold`. On a control-flow redirect it discards wrong-path fetches and presents the decode stage with a valid/instruction/PC triple.

---
 rtl/if_id_stage.sv | 127 ++++++++++++
 tb/tb_if_id_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Fetch return path + IF/ID register: pairs each late SRAM word with its PC and feeds decode.
// Latency: fetch_pc to id_pc is 2 cycles; a redirect costs 2 bubble cycles.
// Backpressure: decode stalls fill a 2-entry skid FIFO; pc_hold freezes the PC before it overflows.
module if_id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] im_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  output logic        pc_hold,
  output logic        im_en,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // In-flight fetch: f_valid_q means im_rdata belongs to f_pc_q this cycle
  logic        f_valid_q;
  logic [31:0] f_pc_q;

  // Skid FIFO storage and bookkeeping
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        has_entry;
  logic        avail;
  logic        take;
  logic        push;
  logic        pop;
  logic        issue;
  logic [2:0]  occ_next;
  logic [31:0] head_pc;
  logic [31:0] head_inst;

  // Head selection, hand-off decisions and PC backpressure
  always_comb begin
    has_entry = (count != 2'd0);
    avail     = has_entry | f_valid_q;
    head_pc   = has_entry ? fifo_pc[rd_ptr]   : f_pc_q;
    head_inst = has_entry ? fifo_inst[rd_ptr] : im_rdata;
    take      = avail & ~id_stall & ~redirect;
    // The arriving word only needs buffering if the bypass did not hand it straight to IF/ID
    push      = f_valid_q & ~redirect & ~(take & ~has_entry);
    pop       = take & has_entry;
    // take implies something is available, so this never underflows
    occ_next  = {1'b0, count} + {2'b00, f_valid_q} - {2'b00, take};
    issue     = (occ_next <= 3'd1);
    pc_hold   = ~issue;
    im_en     = issue & ~redirect;
  end

  // Track which address the SRAM is returning data for next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_valid_q <= 1'b0;
      f_pc_q    <= 32'h0;
    end else begin
      f_valid_q <= issue & ~redirect;
      f_pc_q    <= fetch_pc;
    end
  end

  // Skid FIFO pointers and occupancy; a redirect flushes everything buffered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Skid FIFO storage; cleared on reset so no stale words survive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]   <= 32'h0;
        fifo_inst[i] <= NOP;
      end
    end else if (push) begin
      fifo_pc[wr_ptr]   <= f_pc_q;
      fifo_inst[wr_ptr] <= im_rdata;
    end
  end

  // IF/ID register: redirect beats stall, stall holds, otherwise load head or insert a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_inst  <= NOP;
      id_pc    <= 32'h0;
    end else if (redirect) begin
      id_valid <= 1'b0;
      id_inst  <= NOP;
      id_pc    <= 32'h0;
    end else if (id_stall) begin
      id_valid <= id_valid;
      id_inst  <= id_inst;
      id_pc    <= id_pc;
    end else if (take) begin
      id_valid <= 1'b1;
      id_inst  <= head_inst;
      id_pc    <= head_pc;
    end else begin
      id_valid <= 1'b0;
      id_inst  <= NOP;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: models the PC register and instruction SRAM around the block,
// and predicts decode-side behaviour from program order plus the buffering rules.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_pc;
  logic [31:0] im_rdata;
  logic        id_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] target = 32'h0;
  logic        pc_hold;
  logic        im_en;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  if_id_stage dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_pc (fetch_pc),
    .im_rdata (im_rdata),
    .id_stall (id_stall),
    .redirect (redirect),
    .pc_hold  (pc_hold),
    .im_en    (im_en),
    .id_valid (id_valid),
    .id_inst  (id_inst),
    .id_pc    (id_pc)
  );

  always #5 clk = ~clk;

  // Program image: the word at PC a is 0x100 + a/4
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  // PC register: redirect loads target, pc_hold freezes, otherwise +4
  always @(posedge clk or posedge rst) begin
    if (rst)            fetch_pc <= 32'h0;
    else if (redirect)  fetch_pc <= target;
    else if (!pc_hold)  fetch_pc <= fetch_pc + 32'd4;
  end

  // Synchronous instruction SRAM
  always @(posedge clk) begin
    if (im_en) im_rdata <= mem_word(fetch_pc);
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_pc;      // next program-order PC owed to decode
  logic        m_v;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  int          warm;        // edges since the last redirect/reset release
  logic        last_issue;  // a fetch was issued in the previous cycle

  task automatic model_reset();
    exp_pc     = 32'h0;
    m_v        = 1'b0;
    m_inst     = NOP;
    m_pc       = 32'h0;
    warm       = 0;
    last_issue = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_id_inst",  id_inst, NOP);
    check("rst_id_pc",    id_pc, 32'h0);
    check("rst_pc_hold",  32'(pc_hold), 32'h0);
    check("rst_im_en",    32'(im_en), 32'h1);
    check("rst_count",    32'(dut.count), 32'h0);
  endtask

  // Drive one cycle's inputs, compare against the model, then advance the model past the edge
  task automatic eval(input logic s, input logic r, input logic [31:0] t);
    logic [31:0] pending;
    logic        can_take;
    logic        e_hold;
    logic        e_en;
    id_stall = s;
    redirect = r;
    target   = t;
    #1;
    check("id_valid", 32'(id_valid), 32'(m_v));
    check("id_inst",  id_inst, m_inst);
    check("id_pc",    id_pc, m_pc);
    // Words fetched but not yet handed to decode
    pending  = (fetch_pc - exp_pc) >> 2;
    can_take = (warm >= 1) && !s && !r;
    e_hold   = ((pending - 32'(can_take)) >= 32'd2);
    e_en     = !r && !e_hold;
    if (!r) check("pc_hold", 32'(pc_hold), 32'(e_hold));
    check("im_en", 32'(im_en), 32'(e_en));
    check("count", 32'(dut.count), pending - 32'(last_issue));
    check("count_max", 32'(dut.count <= 2'd2), 32'h1);
    if (r) begin
      m_v    = 1'b0;
      m_inst = NOP;
      m_pc   = 32'h0;
      exp_pc = t;
      warm   = 0;
    end else begin
      if (!s) begin
        if (can_take) begin
          m_v    = 1'b1;
          m_pc   = exp_pc;
          m_inst = mem_word(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end else begin
          m_v    = 1'b0;
          m_inst = NOP;
        end
      end
      if (warm < 2) warm++;
    end
    last_issue = e_en;
  endtask

  task automatic run_cycle(input logic s, input logic r, input logic [31:0] t);
    @(posedge clk);
    #1;
    eval(s, r, t);
  endtask

  // Hold reset across edges, check, then release mid-cycle; that cycle is cycle 0
  task automatic reset_and_release();
    @(posedge clk);
    @(posedge clk);
    #2;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    eval(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    reset_and_release();

    // Free-run: id_pc = 0x10 is on IF/ID at cycle 6
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 32'h0);

    // Five-cycle stall, then release and drain
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 32'h0);

    // Redirect at steady state
    run_cycle(1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 32'h0);

    // Fill the FIFO to 2, then redirect and stall together
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b1, 32'h300);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 32'h0);

    // Single-cycle stall pulses every other cycle
    for (int i = 0; i < 20; i++) run_cycle((i % 2) == 0, 1'b0, 32'h0);

    // Random stalls and redirects
    for (int i = 0; i < 300; i++) begin
      logic        s;
      logic        r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 19) == 0);
      t = 32'($urandom_range(0, 1023)) << 2;
      run_cycle(s, r, t);
    end

    // Reach count=2 with a valid instruction on IF/ID, then reset asynchronously mid-cycle
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("pre_rst_count", 32'(dut.count), 32'h2);
    check("pre_rst_valid", 32'(id_valid), 32'h1);
    rst = 1'b1;
    #1;
    check_reset_state();
    id_stall = 1'b0;
    reset_and_release();
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
